// File: rtl/key_entry_fsm.sv
// Keypad entry controller: select a field, type decimal digits, confirm to commit a setpoint.
// Produces one-cycle commit/error/timeout strobes plus the live entry state for the display.
module key_entry_fsm #(
    parameter int MAX_DIGITS  = 2,
    parameter int VAL_W       = 7,
    parameter int MAX_VAL     = 99,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [3:0]       ins,
    output logic             busy,
    output logic [1:0]       cur_sel,
    output logic [VAL_W-1:0] cur_val,
    output logic [1:0]       digit_cnt,
    output logic             out_valid,
    output logic [1:0]       out_sel,
    output logic [VAL_W-1:0] out_value,
    output logic             err,
    output logic             timeout
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int WIDE_W = VAL_W + 4;
    localparam logic [WIDE_W-1:0] TEN = WIDE_W'(10);
    localparam logic [WIDE_W-1:0] MAX_VAL_W = WIDE_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {
        IDLE,
        ENTRY
    } state_t;

    state_t             state_q, state_d;
    logic               push_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         curSel_q, curSel_d;
    logic [VAL_W-1:0]   curVal_q, curVal_d;
    logic [1:0]         digitCnt_q, digitCnt_d;
    logic               outValid_q, outValid_d;
    logic [1:0]         outSel_q, outSel_d;
    logic [VAL_W-1:0]   outValue_q, outValue_d;
    logic               err_q, err_d;
    logic               timeout_q, timeout_d;

    logic               keyEvent;
    logic [WIDE_W-1:0]  curValWide;
    logic [WIDE_W-1:0]  nextValWide;

    assign keyEvent    = push & ~push_q;
    assign curValWide  = {4'b0000, curVal_q};
    assign nextValWide = curValWide * TEN + {VAL_W'(0), ins};

    // push_q resets high so a key already held at reset release is not seen as a new press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            push_q     <= 1'b1;
            cnt_q      <= '0;
            curSel_q   <= '0;
            curVal_q   <= '0;
            digitCnt_q <= '0;
            outValid_q <= 1'b0;
            outSel_q   <= '0;
            outValue_q <= '0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            push_q     <= push;
            cnt_q      <= cnt_d;
            curSel_q   <= curSel_d;
            curVal_q   <= curVal_d;
            digitCnt_q <= digitCnt_d;
            outValid_q <= outValid_d;
            outSel_q   <= outSel_d;
            outValue_q <= outValue_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        curSel_d   = curSel_q;
        curVal_d   = curVal_q;
        digitCnt_d = digitCnt_q;
        outValid_d = 1'b0;
        outSel_d   = outSel_q;
        outValue_d = outValue_q;
        err_d      = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (keyEvent && ins >= 4'd12) begin
                    state_d    = ENTRY;
                    curSel_d   = ins[1:0];
                    curVal_d   = '0;
                    digitCnt_d = '0;
                end
            end
            ENTRY: begin
                // a key press in the expiry cycle takes priority over the timeout
                if (keyEvent) begin
                    cnt_d = '0;
                    if (ins <= 4'd9) begin
                        if (digitCnt_q < 2'(MAX_DIGITS)) begin
                            curVal_d   = nextValWide[VAL_W-1:0];
                            digitCnt_d = digitCnt_q + 2'd1;
                        end
                    end else if (ins == 4'd10) begin
                        if (digitCnt_q == 2'd0) begin
                            err_d = 1'b1;
                        end else if (curValWide > MAX_VAL_W) begin
                            err_d      = 1'b1;
                            curVal_d   = '0;
                            digitCnt_d = '0;
                        end else begin
                            outValid_d = 1'b1;
                            outSel_d   = curSel_q;
                            outValue_d = curVal_q;
                            state_d    = IDLE;
                            curVal_d   = '0;
                            digitCnt_d = '0;
                        end
                    end else if (ins == 4'd11) begin
                        curVal_d   = '0;
                        digitCnt_d = '0;
                        if (digitCnt_q == 2'd0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        curSel_d   = ins[1:0];
                        curVal_d   = '0;
                        digitCnt_d = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = '0;
                    curSel_d   = '0;
                    curVal_d   = '0;
                    digitCnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == ENTRY);
    assign cur_sel   = curSel_q;
    assign cur_val   = curVal_q;
    assign digit_cnt = digitCnt_q;
    assign out_valid = outValid_q;
    assign out_sel   = outSel_q;
    assign out_value = outValue_q;
    assign err       = err_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_key_entry_fsm.sv
// Directed bench for key_entry_fsm: two instances (MAX_VAL 99 and 40, both with a short timeout)
// driven from a key/expected-output table plus hand sequences for reset, timeout and async reset.
module tb_key_entry_fsm;

    localparam int VAL_W = 7;

    logic             clk;
    logic             rst_n;
    logic             pushA, pushB;
    logic [3:0]       insA, insB;
    logic             busyA, busyB;
    logic [1:0]       curSelA, curSelB;
    logic [VAL_W-1:0] curValA, curValB;
    logic [1:0]       digitCntA, digitCntB;
    logic             outValidA, outValidB;
    logic [1:0]       outSelA, outSelB;
    logic [VAL_W-1:0] outValueA, outValueB;
    logic             errA, errB;
    logic             timeoutA, timeoutB;

    int passCount;
    int totalCount;

    typedef struct {
        int          which;
        logic [3:0]  key;
        logic [23:0] expected;
    } vec_t;

    vec_t vecs[$];

    key_entry_fsm #(.MAX_DIGITS(2), .VAL_W(VAL_W), .MAX_VAL(99), .TIMEOUT_CYC(100)) dutA (
        .clk(clk), .rst_n(rst_n), .push(pushA), .ins(insA),
        .busy(busyA), .cur_sel(curSelA), .cur_val(curValA), .digit_cnt(digitCntA),
        .out_valid(outValidA), .out_sel(outSelA), .out_value(outValueA),
        .err(errA), .timeout(timeoutA)
    );

    key_entry_fsm #(.MAX_DIGITS(2), .VAL_W(VAL_W), .MAX_VAL(40), .TIMEOUT_CYC(100)) dutB (
        .clk(clk), .rst_n(rst_n), .push(pushB), .ins(insB),
        .busy(busyB), .cur_sel(curSelB), .cur_val(curValB), .digit_cnt(digitCntB),
        .out_valid(outValidB), .out_sel(outSelB), .out_value(outValueB),
        .err(errB), .timeout(timeoutB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic b, input logic [1:0] s, input logic [6:0] v,
                                       input logic [1:0] c, input logic ov, input logic [1:0] os,
                                       input logic [6:0] oval, input logic e, input logic t);
        return {b, s, v, c, ov, os, oval, e, t};
    endfunction

    function automatic logic [23:0] getOut(input int which);
        if (which == 0)
            return {busyA, curSelA, curValA, digitCntA, outValidA, outSelA, outValueA, errA, timeoutA};
        return {busyB, curSelB, curValB, digitCntB, outValidB, outSelB, outValueB, errB, timeoutB};
    endfunction

    function automatic logic anyPulse(input int which);
        if (which == 0) return outValidA | errA | timeoutA;
        return outValidB | errB | timeoutB;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input int which, input logic p, input logic [3:0] k);
        if (which == 0) begin
            pushA = p;
            insA  = k;
        end else begin
            pushB = p;
            insB  = k;
        end
    endtask

    // Press a key, sample the registered response just after the event edge, then hold and release
    task automatic applyStimulus(input int which, input logic [3:0] k, output logic [23:0] resp,
                                 output logic extraPulse);
        @(negedge clk);
        drive(which, 1'b1, k);
        @(posedge clk);
        #1;
        resp = getOut(which);
        extraPulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) drive(which, 1'b0, k);
            @(posedge clk);
            #1;
            extraPulse = extraPulse | anyPulse(which);
        end
    endtask

    task automatic addVec(input int which, input logic [3:0] k, input logic [23:0] e);
        vec_t v;
        v.which    = which;
        v.key      = k;
        v.expected = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [23:0] resp;
        logic        extra;
        logic        activity;
        int          found;

        passCount  = 0;
        totalCount = 0;

        // Table A: MAX_VAL 99
        addVec(0, 4'd13, mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        addVec(0, 4'd2,  mk(1, 1, 2, 1, 0, 0, 0, 0, 0));
        addVec(0, 4'd5,  mk(1, 1, 25, 2, 0, 0, 0, 0, 0));
        addVec(0, 4'd10, mk(0, 1, 0, 0, 1, 1, 25, 0, 0));
        addVec(0, 4'd12, mk(1, 0, 0, 0, 0, 1, 25, 0, 0));
        addVec(0, 4'd9,  mk(1, 0, 9, 1, 0, 1, 25, 0, 0));
        addVec(0, 4'd9,  mk(1, 0, 99, 2, 0, 1, 25, 0, 0));
        addVec(0, 4'd7,  mk(1, 0, 99, 2, 0, 1, 25, 0, 0));
        addVec(0, 4'd10, mk(0, 0, 0, 0, 1, 0, 99, 0, 0));
        addVec(0, 4'd15, mk(1, 3, 0, 0, 0, 0, 99, 0, 0));
        addVec(0, 4'd10, mk(1, 3, 0, 0, 0, 0, 99, 1, 0));
        addVec(0, 4'd11, mk(0, 3, 0, 0, 0, 0, 99, 0, 0));
        addVec(0, 4'd7,  mk(0, 3, 0, 0, 0, 0, 99, 0, 0));
        addVec(0, 4'd14, mk(1, 2, 0, 0, 0, 0, 99, 0, 0));
        addVec(0, 4'd3,  mk(1, 2, 3, 1, 0, 0, 99, 0, 0));
        addVec(0, 4'd11, mk(1, 2, 0, 0, 0, 0, 99, 0, 0));
        addVec(0, 4'd6,  mk(1, 2, 6, 1, 0, 0, 99, 0, 0));
        addVec(0, 4'd12, mk(1, 0, 0, 0, 0, 0, 99, 0, 0));
        addVec(0, 4'd0,  mk(1, 0, 0, 1, 0, 0, 99, 0, 0));
        addVec(0, 4'd11, mk(1, 0, 0, 0, 0, 0, 99, 0, 0));
        addVec(0, 4'd11, mk(0, 0, 0, 0, 0, 0, 99, 0, 0));
        // Table B: MAX_VAL 40
        addVec(1, 4'd14, mk(1, 2, 0, 0, 0, 0, 0, 0, 0));
        addVec(1, 4'd5,  mk(1, 2, 5, 1, 0, 0, 0, 0, 0));
        addVec(1, 4'd0,  mk(1, 2, 50, 2, 0, 0, 0, 0, 0));
        addVec(1, 4'd10, mk(1, 2, 0, 0, 0, 0, 0, 1, 0));
        addVec(1, 4'd3,  mk(1, 2, 3, 1, 0, 0, 0, 0, 0));
        addVec(1, 4'd10, mk(0, 2, 0, 0, 1, 2, 3, 0, 0));
        addVec(1, 4'd12, mk(1, 0, 0, 0, 0, 2, 3, 0, 0));
        addVec(1, 4'd4,  mk(1, 0, 4, 1, 0, 2, 3, 0, 0));
        addVec(1, 4'd0,  mk(1, 0, 40, 2, 0, 2, 3, 0, 0));
        addVec(1, 4'd10, mk(0, 0, 0, 0, 1, 0, 40, 0, 0));
        addVec(1, 4'd13, mk(1, 1, 0, 0, 0, 0, 40, 0, 0));
        addVec(1, 4'd4,  mk(1, 1, 4, 1, 0, 0, 40, 0, 0));
        addVec(1, 4'd1,  mk(1, 1, 41, 2, 0, 0, 40, 0, 0));
        addVec(1, 4'd10, mk(1, 1, 0, 0, 0, 0, 40, 1, 0));
        addVec(1, 4'd11, mk(0, 1, 0, 0, 0, 0, 40, 0, 0));

        // Key held through reset release must not register as a press
        rst_n = 1'b0;
        pushA = 1'b1;
        insA  = 4'd12;
        pushB = 1'b0;
        insB  = 4'd0;
        #2;
        checkOutput("reset_state_A", 32'(getOut(0)), 32'd0);
        checkOutput("reset_state_B", 32'(getOut(1)), 32'd0);
        #21;
        rst_n = 1'b1;
        activity = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            activity = activity | busyA | anyPulse(0);
        end
        checkOutput("held_key_no_event", 32'(activity), 32'd0);
        checkOutput("held_key_state", 32'(getOut(0)), 32'd0);
        @(negedge clk);
        pushA = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].which, vecs[i].key, resp, extra);
            checkOutput($sformatf("vec%0d_key%0d", i, vecs[i].key), 32'(resp), 32'(vecs[i].expected));
            checkOutput($sformatf("vec%0d_pulse_width", i), 32'(extra), 32'd0);
        end

        // Timeout: pulse must appear exactly 100 cycles after the response to key 4
        applyStimulus(0, 4'd12, resp, extra);
        checkOutput("tmo_select", 32'(resp), 32'(mk(1, 0, 0, 0, 0, 0, 99, 0, 0)));
        @(negedge clk);
        pushA = 1'b1;
        insA  = 4'd4;
        @(posedge clk);
        #1;
        checkOutput("tmo_digit", 32'(getOut(0)), 32'(mk(1, 0, 4, 1, 0, 0, 99, 0, 0)));
        found = 0;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            if (n == 2) pushA = 1'b0;
            @(posedge clk);
            #1;
            if (timeoutA) begin
                found = n;
                break;
            end
        end
        checkOutput("tmo_latency", 32'(found), 32'd100);
        checkOutput("tmo_state", 32'(getOut(0)), 32'(mk(0, 0, 0, 0, 0, 0, 99, 0, 1)));
        @(posedge clk);
        #1;
        checkOutput("tmo_one_cycle", 32'(getOut(0)), 32'(mk(0, 0, 0, 0, 0, 0, 99, 0, 0)));

        // Async reset in the middle of an entry clears everything without a clock edge
        applyStimulus(0, 4'd13, resp, extra);
        applyStimulus(0, 4'd7, resp, extra);
        applyStimulus(0, 4'd10, resp, extra);
        checkOutput("pre_rst_commit", 32'(resp), 32'(mk(0, 1, 0, 0, 1, 1, 7, 0, 0)));
        applyStimulus(0, 4'd13, resp, extra);
        applyStimulus(0, 4'd8, resp, extra);
        checkOutput("pre_rst_entry", 32'(resp), 32'(mk(1, 1, 8, 1, 0, 1, 7, 0, 0)));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_A", 32'(getOut(0)), 32'd0);
        checkOutput("async_reset_B", 32'(getOut(1)), 32'd0);
        #20;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
